// File: rtl/dp_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_march_bist
// Description : March C- self-test controller for one dp_ram instance, with
//               pass/fail reporting and first-failure capture.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_march_bist #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_mask_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WRITE  = 3'd1;
    localparam logic [2:0] c_READ   = 3'd2;
    localparam logic [2:0] c_WRCHK  = 3'd3;
    localparam logic [2:0] c_RDONLY = 3'd4;
    localparam logic [2:0] c_DRAIN  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MIN = '0;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_P0       = '0;
    localparam logic [DATA_WIDTH-1:0] c_P1       = '1;

    logic [2:0]            r_state;
    logic [2:0]            r_elem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_prev_addr;
    logic                  r_rd_pend;
    logic                  r_fail;
    logic [2:0]            r_fail_elem;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;

    logic                  w_down;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_expect;
    logic                  w_mismatch;

    // E3/E4 walk downwards; every other element walks upwards
    assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_last     = w_down ? (r_addr == c_ADDR_MIN) : (r_addr == c_ADDR_MAX);
    assign w_expect   = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? c_P1 : c_P0;
    assign w_mismatch = (ram_data_out != w_expect);

    assign busy        = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done        = (r_state == c_DONE);
    assign fail        = r_fail;
    assign fail_elem   = r_fail_elem;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign ram_rd_en   = (r_state == c_READ) || (r_state == c_RDONLY);
    assign ram_wr_en   = (r_state == c_WRITE) || (r_state == c_WRCHK);
    assign ram_rd_addr = r_addr;
    assign ram_wr_addr = r_addr;
    assign ram_data_in = (r_state == c_WRCHK) ? ~w_expect : c_P0;
    assign ram_mask_in = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_elem      <= 3'd0;
            r_addr      <= c_ADDR_MIN;
            r_prev_addr <= c_ADDR_MIN;
            r_rd_pend   <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= c_ADDR_MIN;
            r_fail_data <= c_P0;
        end else begin
            // Tracks the pipelined E5 read whose data arrives next cycle
            r_rd_pend   <= (r_state == c_RDONLY);
            r_prev_addr <= r_addr;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state     <= c_WRITE;
                        r_elem      <= 3'd0;
                        r_addr      <= c_ADDR_MIN;
                        r_fail      <= 1'b0;
                        r_fail_elem <= 3'd0;
                        r_fail_addr <= c_ADDR_MIN;
                        r_fail_data <= c_P0;
                    end
                end
                c_WRITE: begin
                    if (r_addr == c_ADDR_MAX) begin
                        r_state <= c_READ;
                        r_elem  <= 3'd1;
                        r_addr  <= c_ADDR_MIN;
                    end else begin
                        r_addr <= r_addr + c_ADDR_ONE;
                    end
                end
                c_READ: begin
                    r_state <= c_WRCHK;
                end
                c_WRCHK: begin
                    if (w_mismatch) begin
                        r_state     <= c_DONE;
                        r_fail      <= 1'b1;
                        r_fail_elem <= r_elem;
                        r_fail_addr <= r_addr;
                        r_fail_data <= ram_data_out;
                    end else if (w_last) begin
                        if (r_elem == 3'd4) begin
                            r_state <= c_RDONLY;
                            r_elem  <= 3'd5;
                            r_addr  <= c_ADDR_MIN;
                        end else begin
                            r_state <= c_READ;
                            r_elem  <= r_elem + 3'd1;
                            // Next element starts at the top when it walks down
                            r_addr  <= (r_elem >= 3'd2) ? c_ADDR_MAX : c_ADDR_MIN;
                        end
                    end else begin
                        r_state <= c_READ;
                        r_addr  <= w_down ? (r_addr - c_ADDR_ONE) : (r_addr + c_ADDR_ONE);
                    end
                end
                c_RDONLY: begin
                    if (r_rd_pend && w_mismatch) begin
                        r_state     <= c_DONE;
                        r_fail      <= 1'b1;
                        r_fail_elem <= r_elem;
                        r_fail_addr <= r_prev_addr;
                        r_fail_data <= ram_data_out;
                    end else if (r_addr == c_ADDR_MAX) begin
                        r_state <= c_DRAIN;
                    end else begin
                        r_addr <= r_addr + c_ADDR_ONE;
                    end
                end
                c_DRAIN: begin
                    r_state <= c_DONE;
                    if (w_mismatch) begin
                        r_fail      <= 1'b1;
                        r_fail_elem <= r_elem;
                        r_fail_addr <= r_prev_addr;
                        r_fail_data <= ram_data_out;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_ram_march_bist
// Description : Directed self-checking bench for dp_ram_march_bist with a
//               behavioural dp_ram and an algorithm-level March C- model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ram_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_data_in, ram_mask_in;
    logic [DW-1:0] ram_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int fault_mode = 0;
    int cur_k = 0;

    logic [DW-1:0] mem [N];

    dp_ram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
        .ram_data_in(ram_data_in), .ram_mask_in(ram_mask_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Fault 1: bit0 stuck at 0 at address 5. Fault 2: bit7 flips on reads of address 3 in E5.
    function automatic logic [DW-1:0] stored(input int fm, input int a, input logic [DW-1:0] d);
        return (fm == 1 && a == 5) ? (d & 8'hFE) : d;
    endfunction

    function automatic logic [DW-1:0] seen(input int fm, input int a, input bit in_e5, input logic [DW-1:0] d);
        return (fm == 2 && a == 3 && in_e5) ? (d ^ 8'h80) : d;
    endfunction

    always @(posedge clk) begin
        if (ram_wr_en)
            mem[ram_wr_addr] <= stored(fault_mode, int'(ram_wr_addr),
                                       (mem[ram_wr_addr] & ~ram_mask_in) | (ram_data_in & ram_mask_in));
        if (ram_rd_en)
            ram_data_out <= seen(fault_mode, int'(ram_rd_addr),
                                 (cur_k >= 9*N+1 && cur_k <= 10*N), mem[ram_rd_addr]);
    end

    // Expected RAM operation in busy cycle k (1-based) of a fault-free run
    function automatic void ref_op(input int k, output bit rd, output bit wr, output int addr,
                                   output logic [DW-1:0] wd);
        int j, e, p, i;
        rd = 0; wr = 0; addr = 0; wd = '0;
        if (k <= N) begin
            wr = 1; addr = k - 1;
        end else if (k <= 9*N) begin
            j = k - N - 1; e = 1 + j / (2*N); p = j % (2*N); i = p / 2;
            addr = (e >= 3) ? (N - 1 - i) : i;
            if (p % 2 == 0) rd = 1;
            else begin wr = 1; wd = (e == 2 || e == 4) ? 8'h00 : 8'hFF; end
        end else if (k <= 10*N) begin
            rd = 1; addr = k - 9*N - 1;
        end
    endfunction

    // Algorithm-level March C- over a faulty memory: first mismatch and last busy cycle
    function automatic void model_run(input int fm, output int last_busy, output bit f,
                                      output int fe, output int fa, output logic [DW-1:0] fd);
        logic [DW-1:0] m [N];
        logic [DW-1:0] ex, r;
        int a;
        f = 0; fe = 0; fa = 0; fd = '0; last_busy = 10*N + 1;
        for (int i = 0; i < N; i++) m[i] = stored(fm, i, 8'h00);
        for (int e = 1; e <= 4; e++) begin
            ex = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            for (int i = 0; i < N; i++) begin
                a = (e >= 3) ? (N - 1 - i) : i;
                r = seen(fm, a, 0, m[a]);
                if (r != ex) begin
                    f = 1; fe = e; fa = a; fd = r; last_busy = 2 + N + (e-1)*2*N + 2*i;
                    return;
                end
                m[a] = stored(fm, a, ~ex);
            end
        end
        for (int i = 0; i < N; i++) begin
            r = seen(fm, i, 1, m[i]);
            if (r != 8'h00) begin
                f = 1; fe = 5; fa = i; fd = r; last_busy = 2 + 9*N + i;
                return;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cur_k);
        end
    endtask

    task automatic check_cycle(input int k);
        bit rd, wr; int a; logic [DW-1:0] wd;
        ref_op(k, rd, wr, a, wd);
        chk("busy", busy, 1);
        chk("rd_en", ram_rd_en, rd);
        chk("wr_en", ram_wr_en, wr);
        chk("mask", ram_mask_in, 8'hFF);
        if (rd) chk("rd_addr", ram_rd_addr, a);
        if (wr) begin
            chk("wr_addr", ram_wr_addr, a);
            chk("wr_data", ram_data_in, wd);
        end
        if (k == 1) begin
            chk("cleared_done", done, 0);
            chk("cleared_fail", {fail, fail_elem, fail_addr, fail_data}, 0);
        end
        // Hand-picked address-order points: E1 start, E3 start/end
        if (k == 17)  chk("e1_first_rd", ram_rd_addr, 0);
        if (k == 81)  chk("e3_first_rd", ram_rd_addr, 15);
        if (k == 82)  chk("e3_first_wr", ram_wr_addr, 15);
        if (k == 111) chk("e3_last_rd", ram_rd_addr, 0);
    endtask

    task automatic run_test(input int fm, input bit hold, input int lit_busy, input bit lit_fail,
                            input int lit_elem, input int lit_addr, input int lit_data);
        int last, fe, fa, nbusy;
        bit f;
        logic [DW-1:0] fd;
        fault_mode = fm;
        model_run(fm, last, f, fe, fa, fd);
        nbusy = 0;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            cur_k = k;
            if (!hold || k == last) start = 1'b0;
            if (busy) nbusy++;
            check_cycle(k);
        end
        @(negedge clk);
        cur_k = 0;
        chk("busy_count", nbusy, lit_busy);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("en_end", {ram_rd_en, ram_wr_en}, 0);
        chk("fail", fail, f);
        chk("fail_lit", fail, lit_fail);
        if (f) begin
            chk("fail_elem", fail_elem, fe);
            chk("fail_addr", fail_addr, fa);
            chk("fail_data", fail_data, fd);
            chk("fail_elem_lit", fail_elem, lit_elem);
            chk("fail_addr_lit", fail_addr, lit_addr);
            chk("fail_data_lit", fail_data, lit_data);
        end else begin
            for (int i = 0; i < N; i++) chk("mem_zero", mem[i], 0);
        end
        repeat (3) @(negedge clk);
        chk("done_hold", {done, busy, fail}, {1'b1, 1'b0, f});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 8'h5A;
        ram_data_out = '0;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {busy, done, fail}, 0);
        chk("rst_fail_info", {fail_elem, fail_addr, fail_data}, 0);
        chk("rst_ram", {ram_rd_en, ram_wr_en, ram_rd_addr, ram_wr_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_test(0, 0, 161, 0, 0, 0, 0);           // clean pass
        run_test(1, 0, 60, 1, 2, 5, 8'hFE);        // stuck-at bit0 at addr 5
        run_test(0, 1, 161, 0, 0, 0, 0);           // restart from failing DONE, start held
        run_test(2, 0, 149, 1, 5, 3, 8'h80);       // E5-only read flip at addr 3

        // Reset mid-test at cycle 50
        fault_mode = 0;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            cur_k = k;
            start = 1'b0;
            check_cycle(k);
        end
        rst = 1'b1;
        @(negedge clk);
        cur_k = 0;
        rst = 1'b0;
        chk("abort_flags", {busy, done, fail, ram_rd_en, ram_wr_en}, 0);
        chk("abort_info", {fail_elem, fail_addr, fail_data, ram_rd_addr, ram_wr_addr}, 0);
        run_test(0, 0, 161, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
